dac_window_sequencer: RTL and testbench

- Sample-rate controller for the DAC window-discriminator path.
- Detects a rising edge on a selected trigger channel's threshold output, runs a per-sample state counter, and qualifies a second channel's threshold output against a programmable [start, stop) window.
- Drives the shared fsm_state_counter bus seen by every DAC filter. Reports hit/miss pulses, a hit tally and its FSM state.
- Clocked by state_clk, which ticks once per sample frame.

---
 rtl/dac_window_sequencer.sv | 127 ++++++++++++
 tb/tb_dac_window_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_window_sequencer.sv
// rtl/dac_window_sequencer.sv - trigger-edge sequencer for the DAC window discriminator
// Runs a per-sample state counter after a trigger edge and qualifies a condition channel in [start, stop).
module dac_window_sequencer #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              state_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] thrsh_in,
  input  logic [SEL_W-1:0]  trig_sel,
  input  logic [SEL_W-1:0]  cond_sel,
  input  logic [CNT_W-1:0]  win_start,
  input  logic [CNT_W-1:0]  win_stop,
  input  logic [CNT_W-1:0]  timeout,
  input  logic [CNT_W-1:0]  holdoff,
  input  logic              clear_count,
  output logic [CNT_W-1:0]  state_counter,
  output logic [1:0]        state_out,
  output logic              busy,
  output logic              hit_pulse,
  output logic              miss_pulse,
  output logic [CNT_W-1:0]  hit_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    HOLDOFF = 2'b10
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hit_count_q;
  logic             busy_q;
  logic             hit_pulse_q;
  logic             miss_pulse_q;
  logic             trig_prev_q;

  logic             trig_lvl;
  logic             trig_edge;
  logic             cond_lvl;
  logic             inwin;
  logic [CNT_W-1:0] cnt_inc_d;
  logic [CNT_W-1:0] hit_inc_d;

  assign trig_lvl  = thrsh_in[trig_sel];
  assign trig_edge = trig_lvl & ~trig_prev_q;
  assign cond_lvl  = thrsh_in[cond_sel];
  assign inwin     = (cnt_q >= win_start) && (cnt_q < win_stop);

  // Both counters stick at all-ones rather than wrapping back to zero.
  assign cnt_inc_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign hit_inc_d = (hit_count_q == '1) ? hit_count_q : hit_count_q + 1'b1;

  always_ff @(posedge state_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hit_count_q  <= '0;
      busy_q       <= 1'b0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      trig_prev_q  <= 1'b0;
    end else begin
      trig_prev_q  <= trig_lvl;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      // Disable outranks any hit or timeout pending in this cycle.
      if (!enable) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (trig_edge) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
          RUN: begin
            if (cond_lvl && inwin) begin
              hit_pulse_q <= 1'b1;
              hit_count_q <= hit_inc_d;
              cnt_q       <= '0;
              state_q     <= HOLDOFF;
            end else if (cnt_q == timeout) begin
              miss_pulse_q <= 1'b1;
              cnt_q        <= '0;
              state_q      <= HOLDOFF;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          HOLDOFF: begin
            if (cnt_q == holdoff) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
        endcase
      end
      if (clear_count) begin
        hit_count_q <= '0;
      end
    end
  end

  assign state_counter = cnt_q;
  assign state_out     = state_q;
  assign busy          = busy_q;
  assign hit_pulse     = hit_pulse_q;
  assign miss_pulse    = miss_pulse_q;
  assign hit_count     = hit_count_q;

endmodule

// File: tb/tb_dac_window_sequencer.sv
// tb/tb_dac_window_sequencer.sv - directed bench with pulse scoreboard for dac_window_sequencer
module tb_dac_window_sequencer;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int CW     = 16;
  localparam int SW     = 6;

  logic              state_clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [NUM_CH-1:0] thrsh_in;
  logic [SEL_W-1:0]  trig_sel;
  logic [SEL_W-1:0]  cond_sel;
  logic [CW-1:0]     win_start;
  logic [CW-1:0]     win_stop;
  logic [CW-1:0]     timeout;
  logic [CW-1:0]     holdoff;
  logic              clear_count;

  logic [CW-1:0]     state_counter;
  logic [1:0]        state_out;
  logic              busy;
  logic              hit_pulse;
  logic              miss_pulse;
  logic [CW-1:0]     hit_count;

  logic [SW-1:0]     s_state_counter;
  logic [1:0]        s_state_out;
  logic              s_busy;
  logic              s_hit_pulse;
  logic              s_miss_pulse;
  logic [SW-1:0]     s_hit_count;

  typedef struct packed {
    logic          is_hit;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic          mon_ok;
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [CW-1:0] exp_hits;

  always #5 state_clk = ~state_clk;

  dac_window_sequencer #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .CNT_W(CW)) dut (
    .state_clk     (state_clk),
    .reset         (reset),
    .enable        (enable),
    .thrsh_in      (thrsh_in),
    .trig_sel      (trig_sel),
    .cond_sel      (cond_sel),
    .win_start     (win_start),
    .win_stop      (win_stop),
    .timeout       (timeout),
    .holdoff       (holdoff),
    .clear_count   (clear_count),
    .state_counter (state_counter),
    .state_out     (state_out),
    .busy          (busy),
    .hit_pulse     (hit_pulse),
    .miss_pulse    (miss_pulse),
    .hit_count     (hit_count)
  );

  // Narrow copy so the hit tally can be driven into saturation quickly.
  dac_window_sequencer #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .CNT_W(SW)) dut_sat (
    .state_clk     (state_clk),
    .reset         (reset),
    .enable        (enable),
    .thrsh_in      (thrsh_in),
    .trig_sel      (trig_sel),
    .cond_sel      (cond_sel),
    .win_start     (win_start[SW-1:0]),
    .win_stop      (win_stop[SW-1:0]),
    .timeout       (timeout[SW-1:0]),
    .holdoff       (holdoff[SW-1:0]),
    .clear_count   (clear_count),
    .state_counter (s_state_counter),
    .state_out     (s_state_out),
    .busy          (s_busy),
    .hit_pulse     (s_hit_pulse),
    .miss_pulse    (s_miss_pulse),
    .hit_count     (s_hit_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge state_clk);
    #1;
  endtask

  task automatic push_exp(input logic h, input logic [CW-1:0] c);
    exp_t e;
    e.is_hit = h;
    e.cnt    = c;
    sb.push_back(e);
  endtask

  // Fresh edge on the trigger channel; returns in RUN with counter 0.
  task automatic arm();
    thrsh_in[trig_sel] = 1'b0;
    step(1);
    thrsh_in[trig_sel] = 1'b1;
    step(1);
  endtask

  always @(negedge state_clk) begin
    if (hit_pulse || miss_pulse) begin
      n_checks++;
      mon_ok = 1'b0;
      mon_e  = '0;
      if (sb.size() != 0) begin
        mon_e  = sb.pop_front();
        mon_ok = (hit_pulse === mon_e.is_hit) && (miss_pulse === !mon_e.is_hit) &&
                 (hit_count === mon_e.cnt);
      end
      assert (mon_ok === 1'b1) n_pass++;
      else $error("FAIL sb_pulse observed hit=%0b miss=%0b count=%0h expected hit=%0b count=%0h",
                  hit_pulse, miss_pulse, hit_count, mon_e.is_hit, mon_e.cnt);
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; thrsh_in = '0; clear_count = 1'b0;
    trig_sel = 3'd2; cond_sel = 3'd5;
    win_start = 16'd10; win_stop = 16'd20; timeout = 16'd100; holdoff = 16'd4;
    step(2);
    chk("rst_state", state_out, 2'b00);
    chk("rst_cnt", state_counter, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hit", hit_pulse, 0);
    chk("rst_miss", miss_pulse, 0);
    chk("rst_count", hit_count, 0);
    reset = 1'b0; enable = 1'b1;
    step(1);

    thrsh_in[2] = 1'b1;
    step(1);
    chk("t1_run_state", state_out, 2'b01);
    chk("t1_run_cnt0", state_counter, 0);
    chk("t1_run_busy", busy, 1);
    step(12);
    chk("t1_cnt12", state_counter, 12);
    thrsh_in[5] = 1'b1;
    push_exp(1'b1, 16'd1);
    step(1);
    chk("t1_hit", hit_pulse, 1);
    chk("t1_hold_state", state_out, 2'b10);
    chk("t1_hold_cnt0", state_counter, 0);
    chk("t1_count", hit_count, 1);
    thrsh_in[5] = 1'b0;
    step(1);
    chk("t1_hit_onecycle", hit_pulse, 0);
    step(3);
    chk("t1_hold_cnt4", state_counter, 4);
    chk("t1_hold_still", state_out, 2'b10);
    step(1);
    chk("t1_idle", state_out, 2'b00);
    chk("t1_idle_busy", busy, 0);

    arm();
    step(9);
    thrsh_in[5] = 1'b1;
    step(1);
    thrsh_in[5] = 1'b0;
    chk("t2_nohit_9", hit_pulse, 0);
    chk("t2_cnt10", state_counter, 10);
    step(10);
    thrsh_in[5] = 1'b1;
    step(1);
    thrsh_in[5] = 1'b0;
    chk("t2_nohit_20", hit_pulse, 0);
    chk("t2_cnt21", state_counter, 21);
    push_exp(1'b0, 16'd1);
    step(79);
    chk("t2_cnt100", state_counter, 100);
    step(1);
    chk("t2_miss", miss_pulse, 1);
    chk("t2_miss_hold", state_out, 2'b10);
    step(5);
    chk("t2_idle", state_out, 2'b00);

    win_start = 16'd30; win_stop = 16'd30;
    arm();
    thrsh_in[5] = 1'b1;
    push_exp(1'b0, 16'd1);
    step(100);
    chk("t3_nohit", hit_pulse, 0);
    step(1);
    chk("t3_miss", miss_pulse, 1);
    chk("t3_count", hit_count, 1);
    thrsh_in[5] = 1'b0;
    step(5);

    win_start = 16'd40; win_stop = 16'd60;
    enable = 1'b0;
    thrsh_in[2] = 1'b0;
    step(1);
    thrsh_in[2] = 1'b1;
    step(2);
    chk("t4_disabled_edge", state_out, 2'b00);
    enable = 1'b1;
    step(3);
    chk("t4_level_no_trig", state_out, 2'b00);
    arm();
    chk("t4_rearm_state", state_out, 2'b01);
    chk("t4_rearm_cnt", state_counter, 0);

    step(50);
    chk("t5_cnt50", state_counter, 50);
    thrsh_in[5] = 1'b1;
    enable = 1'b0;
    step(1);
    chk("t5_dis_state", state_out, 2'b00);
    chk("t5_dis_cnt", state_counter, 0);
    chk("t5_dis_hit", hit_pulse, 0);
    chk("t5_dis_count", hit_count, 1);
    thrsh_in[5] = 1'b0;
    enable = 1'b1;
    win_start = 16'd10; win_stop = 16'd20;
    arm();
    step(15);
    thrsh_in[5] = 1'b1;
    clear_count = 1'b1;
    push_exp(1'b1, 16'd0);
    step(1);
    chk("t5_clr_hit", hit_pulse, 1);
    chk("t5_clr_count", hit_count, 0);
    thrsh_in[5] = 1'b0;
    clear_count = 1'b0;
    step(5);

    arm();
    step(5);
    thrsh_in = '0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst_run_state", state_out, 2'b00);
    chk("rst_run_cnt", state_counter, 0);
    chk("rst_run_busy", busy, 0);

    trig_sel = 3'd0; cond_sel = 3'd0;
    win_start = 16'd0; win_stop = 16'd20; timeout = 16'd0; holdoff = 16'd0;
    step(1);
    exp_hits = '0;
    for (int i = 0; i < 71; i++) begin
      thrsh_in[0] = 1'b0;
      step(1);
      thrsh_in[0] = 1'b1;
      exp_hits = (exp_hits == '1) ? exp_hits : exp_hits + 1'b1;
      push_exp(1'b1, exp_hits);
      step(2);
      if (i == 0) begin
        chk("t6_hit_prio", hit_pulse, 1);
        chk("t6_no_miss", miss_pulse, 0);
      end
      step(1);
      if (i == 0) chk("t6_hold0_idle", state_out, 2'b00);
    end
    chk("t6_count", hit_count, 71);
    chk("t6_sat_count", s_hit_count, 6'h3F);

    win_start = 16'd5;
    thrsh_in[0] = 1'b0;
    step(1);
    thrsh_in[0] = 1'b1;
    push_exp(1'b0, exp_hits);
    step(2);
    chk("t6_to0_miss", miss_pulse, 1);
    chk("t6_to0_nohit", hit_pulse, 0);
    step(1);
    chk("t6_to0_idle", state_out, 2'b00);
    step(2);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
